// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light monitor.
// Holds the lamp encodings, the fault codes reported by the monitor,
// the per-road flag bundle and the legal colour successor function.
package traffic_light_pkg;

    // Lamp encodings, {red,yellow,green}
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Fault codes. Lower non-zero value means higher priority.
    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ENCODING = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;
    localparam logic [2:0] FC_STUCK    = 3'd5;

    typedef struct packed {
        logic enc;
        logic seq;
        logic short_dwell;
        logic stuck;
    } road_flags_t;

    // The only colour a road may move to from colour c.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        case (c)
            RED:     next_colour = GREEN;
            GREEN:   next_colour = YELLOW;
            YELLOW:  next_colour = RED;
            default: next_colour = RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_road_chk.sv
// Per-road checker for the traffic light monitor.
// Tracks the stored colour and its dwell count for one road and raises
// same-sample flags for encoding, sequence, short-dwell and stuck faults.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   light           sampled lamp bus {red,yellow,green}
//   flags           fault flags for the current sample (combinational)
//   colour          sampled colour, for the cross-road conflict check
//   colour_valid    sampled colour is a legal encoding
//   yr_event        legal yellow->red change on this sample
module traffic_light_road_chk
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN  = 8,
    parameter int YELLOW_MIN = 2,
    parameter int MAX_DWELL  = 64,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light,
    output road_flags_t flags,
    output logic [2:0]  colour,
    output logic        colour_valid,
    output logic        yr_event
);

    localparam logic [CNT_W-1:0] GREEN_MIN_C  = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] YELLOW_MIN_C = CNT_W'(YELLOW_MIN);
    // Stuck fires on the sample that takes dwell to MAX_DWELL.
    localparam logic [CNT_W-1:0] STUCK_AT     = CNT_W'(MAX_DWELL - 1);
    localparam logic [CNT_W-1:0] DWELL_ONE    = CNT_W'(1);

    logic [2:0]       colour_q;
    logic [CNT_W-1:0] dwell_q;
    logic             armed_q;

    logic             legal;
    logic             same;
    logic             active;
    logic             changed;
    logic [CNT_W-1:0] dwell_inc;

    assign legal     = (light == RED) || (light == YELLOW) || (light == GREEN);
    assign same      = (light == colour_q);
    assign active    = legal && armed_q;
    assign changed   = active && !same;
    assign dwell_inc = (dwell_q == {CNT_W{1'b1}}) ? dwell_q : dwell_q + DWELL_ONE;

    always_comb begin
        flags             = '0;
        flags.enc         = !legal;
        flags.seq         = changed && (light != next_colour(colour_q));
        flags.short_dwell = changed &&
                            (((colour_q == GREEN)  && (dwell_q < GREEN_MIN_C)) ||
                             ((colour_q == YELLOW) && (dwell_q < YELLOW_MIN_C)));
        flags.stuck       = active && same && (dwell_q == STUCK_AT);
    end

    assign colour       = light;
    assign colour_valid = legal;
    assign yr_event     = changed && (colour_q == YELLOW) && (light == RED);

    // An illegal sample leaves colour, dwell and armed untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_q <= RED;
            dwell_q  <= '0;
            armed_q  <= 1'b0;
        end else if (legal) begin
            if (!armed_q) begin
                colour_q <= light;
                dwell_q  <= DWELL_ONE;
                armed_q  <= 1'b1;
            end else if (same) begin
                dwell_q  <= dwell_inc;
            end else begin
                colour_q <= light;
                dwell_q  <= DWELL_ONE;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for a two-road traffic light controller.
// Checks both lamp buses every clock, latches the first fault (code and
// road) and counts completed road-A cycles. Never drives the lights.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   light_A/B     lamp buses {red,yellow,green}
//   fault         sticky fault indication since reset
//   fault_code    code of first fault (see traffic_light_pkg)
//   fault_road    road of first fault, 0=A 1=B (0 for conflict)
//   cycle_count   completed A cycles, counted on A yellow->red, wraps
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN  = 8,
    parameter int YELLOW_MIN = 2,
    parameter int MAX_DWELL  = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_A,
    input  logic [2:0]       light_B,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             fault_road,
    output logic [CNT_W-1:0] cycle_count
);

    road_flags_t flags_a;
    road_flags_t flags_b;
    logic [2:0]  colour_a;
    logic [2:0]  colour_b;
    logic        valid_a;
    logic        valid_b;
    logic        yr_a;
    logic        conflict;
    logic [2:0]  code_nxt;
    logic        road_nxt;

    traffic_light_road_chk #(
        .GREEN_MIN  (GREEN_MIN),
        .YELLOW_MIN (YELLOW_MIN),
        .MAX_DWELL  (MAX_DWELL),
        .CNT_W      (CNT_W)
    ) u_road_a (
        .clk          (clk),
        .rst          (rst),
        .light        (light_A),
        .flags        (flags_a),
        .colour       (colour_a),
        .colour_valid (valid_a),
        .yr_event     (yr_a)
    );

    // Road B's yellow->red pulse has no consumer; only A cycles are counted.
    traffic_light_road_chk #(
        .GREEN_MIN  (GREEN_MIN),
        .YELLOW_MIN (YELLOW_MIN),
        .MAX_DWELL  (MAX_DWELL),
        .CNT_W      (CNT_W)
    ) u_road_b (
        .clk          (clk),
        .rst          (rst),
        .light        (light_B),
        .flags        (flags_b),
        .colour       (colour_b),
        .colour_valid (valid_b),
        .yr_event     ()
    );

    assign conflict = valid_a && valid_b && (colour_a != RED) && (colour_b != RED);

    // Highest-priority code wins; road A wins ties.
    always_comb begin
        code_nxt = FC_NONE;
        road_nxt = 1'b0;
        if (conflict) begin
            code_nxt = FC_CONFLICT;
        end else if (flags_a.enc) begin
            code_nxt = FC_ENCODING;
        end else if (flags_b.enc) begin
            code_nxt = FC_ENCODING;
            road_nxt = 1'b1;
        end else if (flags_a.seq) begin
            code_nxt = FC_SEQUENCE;
        end else if (flags_b.seq) begin
            code_nxt = FC_SEQUENCE;
            road_nxt = 1'b1;
        end else if (flags_a.short_dwell) begin
            code_nxt = FC_SHORT;
        end else if (flags_b.short_dwell) begin
            code_nxt = FC_SHORT;
            road_nxt = 1'b1;
        end else if (flags_a.stuck) begin
            code_nxt = FC_STUCK;
        end else if (flags_b.stuck) begin
            code_nxt = FC_STUCK;
            road_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            fault_road  <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (!fault && (code_nxt != FC_NONE)) begin
                fault      <= 1'b1;
                fault_code <= code_nxt;
                fault_road <= road_nxt;
            end
            if (yr_a) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus a
// randomized phase, all compared against a colour-index reference model.
module tb_traffic_light_monitor;

    localparam int GMIN  = 4;
    localparam int YMIN  = 2;
    localparam int MAXD  = 16;
    localparam int CW    = 8;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    la  = R;
    logic [2:0]    lb  = R;
    logic          fault;
    logic [2:0]    fault_code;
    logic          fault_road;
    logic [CW-1:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state. Colours as cycle index: 0 red, 1 green, 2 yellow.
    int m_col[2];
    int m_dwell[2];
    bit m_armed[2];
    bit m_fault;
    int m_code;
    int m_road;
    int m_cycles;

    traffic_light_monitor #(
        .GREEN_MIN  (GMIN),
        .YELLOW_MIN (YMIN),
        .MAX_DWELL  (MAXD),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light_A     (la),
        .light_B     (lb),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_road  (fault_road),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decode(input logic [2:0] v);
        if (v == R) return 0;
        if (v == G) return 1;
        if (v == Y) return 2;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 2; r++) begin
            m_col[r] = 0; m_dwell[r] = 0; m_armed[r] = 0;
        end
        m_fault = 0; m_code = 0; m_road = 0; m_cycles = 0;
    endfunction

    function automatic void model_sample(input logic [2:0] a, input logic [2:0] b);
        int c[2];
        int best_code;
        int best_road;
        best_code = 0;
        best_road = 0;
        c[0] = decode(a);
        c[1] = decode(b);
        if (c[0] > 0 && c[1] > 0) begin
            best_code = 1;
        end
        for (int r = 0; r < 2; r++) begin
            int cand;
            cand = 0;
            if (c[r] < 0) begin
                cand = 2;
            end else if (!m_armed[r]) begin
                m_col[r] = c[r]; m_dwell[r] = 1; m_armed[r] = 1;
            end else if (c[r] == m_col[r]) begin
                m_dwell[r] = (m_dwell[r] + 1 > 255) ? 255 : m_dwell[r] + 1;
                if (m_dwell[r] == MAXD) cand = 5;
            end else begin
                int sc;
                sc = 0;
                if (m_col[r] == 1 && m_dwell[r] < GMIN) sc = 4;
                if (m_col[r] == 2 && m_dwell[r] < YMIN) sc = 4;
                if (c[r] != (m_col[r] + 1) % 3) sc = 3;
                cand = sc;
                if (r == 0 && m_col[r] == 2 && c[r] == 0) m_cycles = (m_cycles + 1) % 256;
                m_col[r] = c[r];
                m_dwell[r] = 1;
            end
            if (cand != 0 && (best_code == 0 || cand < best_code)) begin
                best_code = cand;
                best_road = r;
            end
        end
        if (!m_fault && best_code != 0) begin
            m_fault = 1; m_code = best_code; m_road = best_road;
        end
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".fault"}, fault, m_fault);
        chk({tag, ".code"},  fault_code, m_code);
        chk({tag, ".road"},  fault_road, m_road);
        chk({tag, ".cycles"}, cycle_count, m_cycles);
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input string tag);
        la = a;
        lb = b;
        @(posedge clk);
        model_sample(a, b);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst.fault", fault, 0);
        chk("rst.code", fault_code, 0);
        chk("rst.road", fault_road, 0);
        chk("rst.cycles", cycle_count, 0);
        rst = 1'b0;
    endtask

    // One legal A/B cycle of 14 samples.
    task automatic legal_cycle14();
        for (int i = 0; i < 14; i++) begin
            logic [2:0] a, b;
            a = (i < 5) ? G : (i < 7) ? Y : R;
            b = (i < 7) ? R : (i < 12) ? G : Y;
            step(a, b, "legal");
        end
    endtask

    // Minimal legal A cycle of 12 samples.
    task automatic legal_cycle12();
        for (int i = 0; i < 12; i++) begin
            logic [2:0] a, b;
            a = (i < 4) ? G : (i < 6) ? Y : R;
            b = (i < 6) ? R : (i < 10) ? G : Y;
            step(a, b, "wrap");
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Legal sequence, three cycles
        for (int k = 0; k < 3; k++) legal_cycle14();
        chk("legal.fault_const", fault, 0);
        chk("legal.cycles_const", cycle_count, 3);

        // Conflict after three legal cycles
        step(G, Y, "conflict");
        chk("conflict.fault_const", fault, 1);
        chk("conflict.code_const", fault_code, 1);
        chk("conflict.road_const", fault_road, 0);

        // Illegal sequence G->R on A, then B encoding error leaves it
        do_reset();
        for (int i = 0; i < 5; i++) step(G, R, "seq_pre");
        step(R, R, "seq");
        chk("seq.code_const", fault_code, 3);
        chk("seq.road_const", fault_road, 0);
        step(R, 3'b110, "seq_enc");
        chk("seq_enc.code_const", fault_code, 3);

        // Short yellow on B
        do_reset();
        for (int i = 0; i < 5; i++) step(R, G, "short_pre");
        step(R, Y, "short_y");
        step(R, R, "short");
        chk("short.code_const", fault_code, 4);
        chk("short.road_const", fault_road, 1);

        // A red stuck for 16 samples
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            logic [2:0] b;
            b = (i <= 5) ? G : (i <= 7) ? Y : R;
            step(R, b, "stuck_run");
            if (i == 15) chk("stuck.before", fault, 0);
        end
        chk("stuck.code_const", fault_code, 5);
        chk("stuck.road_const", fault_road, 0);

        // Collision: A encoding vs B sequence in same sample
        do_reset();
        step(R, R, "coll_pre");
        step(3'b000, Y, "coll");
        chk("coll.code_const", fault_code, 2);
        chk("coll.road_const", fault_road, 0);

        // Reset while faulted, then first sample R/G
        chk("coll.fault_set", fault, 1);
        do_reset();
        step(R, G, "post_rst");
        chk("post_rst.fault_const", fault, 0);

        // Wrap: 255 cycles then one more
        do_reset();
        for (int k = 0; k < 255; k++) legal_cycle12();
        chk("wrap.255", cycle_count, 255);
        legal_cycle12();
        chk("wrap.cycles_const", cycle_count, 0);
        chk("wrap.fault_const", fault, 0);

        // Randomized phase
        do_reset();
        begin
            logic [2:0] ra, rb;
            ra = R;
            rb = R;
            for (int n = 0; n < 3000; n++) begin
                int p;
                if ($urandom_range(0, 199) == 0) begin
                    do_reset();
                end
                p = $urandom_range(0, 99);
                if (p >= 97) ra = 3'($urandom_range(0, 7));
                else if (p >= 85) ra = (ra == R) ? G : (ra == G) ? Y : R;
                p = $urandom_range(0, 99);
                if (p >= 97) rb = 3'($urandom_range(0, 7));
                else if (p >= 85) rb = (rb == R) ? G : (rb == G) ? Y : R;
                step(ra, rb, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
